// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared types and constants for the hazard/forwarding
//               scoreboard: in-flight entry record, register index width,
//               default pipeline geometry and forwarding-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Architectural register index width (16 registers)
    localparam int RW                = 4;

    // Default geometry: EXE, MEM, WB tracked; MEM output first carries loads
    localparam int DEFAULT_DEPTH     = 3;
    localparam int DEFAULT_MEM_STAGE = 1;

    // Forwarding select 0 means "take the operand from the register file";
    // select k means "take the result at the output of entry k".
    localparam int FWD_RF            = 0;

    // One in-flight instruction as seen by the scoreboard
    typedef struct packed {
        logic          valid;
        logic          wb_en;
        logic          mem_read;
        logic [RW-1:0] dest;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_src_check.sv
`default_nettype none
// ============================================================================
// Module      : hazard_src_check
// Description : Combinational check of one ID source register against the
//               scoreboard entries that can still forward (EXE..DEPTH-2).
//               Returns the youngest matching entry and whether that match
//               is a load whose data is not yet available.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_src_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int MEM_STAGE = DEFAULT_MEM_STAGE,
    parameter int FW        = $clog2(DEPTH)
) (
    input  entry_t        i_entries [DEPTH-1],
    input  logic [RW-1:0] i_src,
    input  logic          i_used,
    output logic          o_hit,
    output logic [FW-1:0] o_k,
    output logic          o_load_hazard
);

    // Scan oldest to youngest so the youngest (lowest index) match wins
    always_comb begin
        o_hit         = 1'b0;
        o_k           = '0;
        o_load_hazard = 1'b0;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (i_used && i_entries[i].valid && i_entries[i].wb_en &&
                (i_entries[i].dest == i_src)) begin
                o_hit         = 1'b1;
                o_k           = FW'(i);
                o_load_hazard = i_entries[i].mem_read && (i < MEM_STAGE);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard and forwarding controller beside the ID stage. Keeps
//               a shift register of in-flight destinations, raises a
//               combinational IF/ID hold on unresolvable dependences and
//               registers EXE operand forwarding selects at issue.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RW        = hazard_scoreboard_pkg::RW,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int MEM_STAGE = DEFAULT_MEM_STAGE,
    parameter bit FWD_EN    = 1'b1,
    parameter int FW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rn,
    input  logic [RW-1:0] id_rm,
    input  logic          id_src1,
    input  logic          id_two_src,
    input  logic          id_wb_en,
    input  logic          id_mem_read,
    input  logic [RW-1:0] id_dest,
    output logic          hazard,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b,
    output logic [15:0]   stall_cnt
);

    localparam logic [FW-1:0] C_FWD_RF = FW'(FWD_RF);

    entry_t        r_entries [DEPTH];
    logic [FW-1:0] r_fwd_a;
    logic [FW-1:0] r_fwd_b;
    logic [15:0]   r_stall_cnt;

    logic          w_hit_rn, w_hit_rm;
    logic [FW-1:0] w_k_rn, w_k_rm;
    logic          w_load_rn, w_load_rm;
    logic          w_src_hz_rn, w_src_hz_rm;
    logic          w_issue;

    // The WB entry is never consulted: the write-first register file already
    // makes its result visible to ID in the same cycle.
    hazard_src_check #(
        .DEPTH     (DEPTH),
        .MEM_STAGE (MEM_STAGE),
        .FW        (FW)
    ) u_chk_rn (
        .i_entries     (r_entries[0:DEPTH-2]),
        .i_src         (id_rn),
        .i_used        (id_src1),
        .o_hit         (w_hit_rn),
        .o_k           (w_k_rn),
        .o_load_hazard (w_load_rn)
    );

    hazard_src_check #(
        .DEPTH     (DEPTH),
        .MEM_STAGE (MEM_STAGE),
        .FW        (FW)
    ) u_chk_rm (
        .i_entries     (r_entries[0:DEPTH-2]),
        .i_src         (id_rm),
        .i_used        (id_two_src),
        .o_hit         (w_hit_rm),
        .o_k           (w_k_rm),
        .o_load_hazard (w_load_rm)
    );

    // Stall request: with forwarding only an early load blocks, otherwise any match
    always_comb begin
        w_src_hz_rn = FWD_EN ? w_load_rn : w_hit_rn;
        w_src_hz_rm = FWD_EN ? w_load_rm : w_hit_rm;
        hazard      = id_valid && !flush && (w_src_hz_rn || w_src_hz_rm);
        w_issue     = id_valid && !hazard && !flush && !freeze;
    end

    // Entry shift register, forwarding selects and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_fwd_a     <= C_FWD_RF;
            r_fwd_b     <= C_FWD_RF;
            r_stall_cnt <= '0;
        end else if (!freeze) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_entries[i] <= r_entries[i-1];
            end
            if (w_issue) begin
                r_entries[0] <= '{valid: 1'b1, wb_en: id_wb_en,
                                  mem_read: id_mem_read, dest: id_dest};
                r_fwd_a      <= (FWD_EN && w_hit_rn) ? FW'(w_k_rn + FW'(1)) : C_FWD_RF;
                r_fwd_b      <= (FWD_EN && w_hit_rm) ? FW'(w_k_rm + FW'(1)) : C_FWD_RF;
            end else begin
                r_entries[0] <= '0;
                r_fwd_a      <= C_FWD_RF;
                r_fwd_b      <= C_FWD_RF;
            end
            if (hazard && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
